// File: rtl/agu_scheduler.sv
// Reservation station and oldest-first issue scheduler feeding the AGU.
// Define AGU_SCHED_BYPASS_EN to let a ready dispatch into an empty station load the output directly.

package agu_scheduler_pkg;
    localparam int PRF_TAG_W = 6;
    localparam int ROB_PTR_W = 4;
    localparam int OP_W      = 4;
    localparam int IMM_W     = 16;

    typedef struct packed {
        logic [OP_W-1:0]      operation;
        logic [PRF_TAG_W-1:0] operand_a;
        logic [PRF_TAG_W-1:0] operand_b;
        logic [IMM_W-1:0]     operand_c;
        logic [ROB_PTR_W-1:0] rob_ptr;
    } micro_op_t;
endpackage

module agu_scheduler
    import agu_scheduler_pkg::*;
#(
    parameter int NUM_PHYSICAL_REGS = 64,
    parameter int ROB_LEN           = 16,
    parameter int DEPTH             = 4,
    parameter int NUM_WB            = 2
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic                                               i_disp_p,
    input  micro_op_t                                          i_disp_uop,
    input  logic                                               i_disp_rdy,
    output logic                                               o_disp_full,
    input  logic [NUM_WB-1:0]                                  i_wb_p,
    input  logic [NUM_WB-1:0][$clog2(NUM_PHYSICAL_REGS)-1:0]   i_wb_trgt,
    input  logic                                               i_flush,
    output logic                                               o_uop_p,
    output micro_op_t                                          o_uop,
    input  logic                                               i_agu_stall,
    output logic [$clog2(DEPTH+1)-1:0]                         o_count
);

    localparam int TAG_W = $clog2(NUM_PHYSICAL_REGS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // The uop struct widths are fixed in the package; catch parameter sets that disagree.
    if (DEPTH < 2) begin : g_depth_chk
        $error("agu_scheduler: DEPTH must be at least 2");
    end
    if (TAG_W != PRF_TAG_W) begin : g_tag_chk
        $error("agu_scheduler: NUM_PHYSICAL_REGS does not match micro_op_t tag width");
    end
    if ($clog2(ROB_LEN) != ROB_PTR_W) begin : g_rob_chk
        $error("agu_scheduler: ROB_LEN does not match micro_op_t rob_ptr width");
    end

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rdy_q, rdy_d;
    micro_op_t        uop_q [DEPTH];
    micro_op_t        uop_d [DEPTH];
    logic             out_p_q, out_p_d;
    micro_op_t        out_uop_q, out_uop_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             can_load;
    logic             disp_full;
    logic             accept;
    logic             disp_ready;
    logic             bypass;
    logic             store;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    logic [CNT_W-1:0] wr_idx;

    function automatic logic wb_hit(input logic [TAG_W-1:0] tag,
                                    input logic [NUM_WB-1:0] wb_p,
                                    input logic [NUM_WB-1:0][TAG_W-1:0] wb_t);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_p[k] && (wb_t[k] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        can_load   = !out_p_q || !i_agu_stall;
        disp_full  = (count_q == CNT_W'(DEPTH));
        accept     = i_disp_p && !disp_full && !i_flush;
        disp_ready = i_disp_rdy || wb_hit(i_disp_uop.operand_a, i_wb_p, i_wb_trgt);
`ifdef AGU_SCHED_BYPASS_EN
        bypass     = accept && (count_q == '0) && can_load && disp_ready;
`else
        bypass     = 1'b0;
`endif
        store      = accept && !bypass;
    end

    // Lowest index wins: entry 0 is always the oldest after compaction.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        issue  = can_load && sel_found && !i_flush;
        wr_idx = count_q - CNT_W'(issue);
    end

    always_comb begin
        valid_d = valid_q;
        rdy_d   = rdy_q;
        uop_d   = uop_q;

        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    valid_d[i] = valid_q[i+1];
                    rdy_d[i]   = rdy_q[i+1];
                    uop_d[i]   = uop_q[i+1];
                end
            end
            valid_d[DEPTH-1] = 1'b0;
            rdy_d[DEPTH-1]   = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && wb_hit(uop_d[i].operand_a, i_wb_p, i_wb_trgt)) begin
                rdy_d[i] = 1'b1;
            end
        end

        // Occupied slots stay contiguous, so the first free slot is the post-issue count.
        if (store) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    valid_d[i] = 1'b1;
                    rdy_d[i]   = disp_ready;
                    uop_d[i]   = i_disp_uop;
                end
            end
        end

        if (i_flush) begin
            valid_d = '0;
            rdy_d   = '0;
        end
    end

    always_comb begin
        out_p_d   = out_p_q;
        out_uop_d = out_uop_q;
        if (i_flush) begin
            out_p_d = 1'b0;
        end else if (can_load) begin
            if (bypass) begin
                out_p_d   = 1'b1;
                out_uop_d = i_disp_uop;
            end else if (issue) begin
                out_p_d   = 1'b1;
                out_uop_d = uop_q[sel_idx];
            end else begin
                out_p_d = 1'b0;
            end
        end
        count_d = i_flush ? '0 : (count_q + CNT_W'(store) - CNT_W'(issue));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            valid_q   <= '0;
            rdy_q     <= '0;
            out_p_q   <= 1'b0;
            out_uop_q <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rdy_q     <= rdy_d;
            out_p_q   <= out_p_d;
            out_uop_q <= out_uop_d;
            count_q   <= count_d;
        end
    end

    // Payload needs no reset; valid_q qualifies every use.
    always_ff @(posedge i_clk) begin
        uop_q <= uop_d;
    end

    assign o_disp_full = disp_full;
    assign o_uop_p     = out_p_q;
    assign o_uop       = out_uop_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_agu_scheduler.sv
// Directed bench for agu_scheduler: vector table for issue ordering and wakeup,
// hand sequences for fill, stall, flush and reset.

module tb_agu_scheduler;
    import agu_scheduler_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_disp_p;
    micro_op_t            i_disp_uop;
    logic                 i_disp_rdy;
    logic                 o_disp_full;
    logic [1:0]           i_wb_p;
    logic [1:0][5:0]      i_wb_trgt;
    logic                 i_flush;
    logic                 o_uop_p;
    micro_op_t            o_uop;
    logic                 i_agu_stall;
    logic [2:0]           o_count;

    int n_tests = 0;
    int n_fail  = 0;

    agu_scheduler dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_disp_p    (i_disp_p),
        .i_disp_uop  (i_disp_uop),
        .i_disp_rdy  (i_disp_rdy),
        .o_disp_full (o_disp_full),
        .i_wb_p      (i_wb_p),
        .i_wb_trgt   (i_wb_trgt),
        .i_flush     (i_flush),
        .o_uop_p     (o_uop_p),
        .o_uop       (o_uop),
        .i_agu_stall (i_agu_stall),
        .o_count     (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       dp;
        logic [5:0] da;
        logic [3:0] drob;
        logic       drdy;
        logic [1:0] wp;
        logic [5:0] t0;
        logic [5:0] t1;
        logic       ep;
        logic [5:0] ea;
        logic [3:0] erob;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic micro_op_t mk(input logic [5:0] a, input logic [3:0] rob);
        micro_op_t u;
        u.operation = 4'h3;
        u.operand_a = a;
        u.operand_b = a + 6'd1;
        u.operand_c = {12'h0AB, rob};
        u.rob_ptr   = rob;
        return u;
    endfunction

    function automatic vec_t V(input logic dp, input logic [5:0] da, input logic [3:0] drob,
                               input logic drdy, input logic [1:0] wp, input logic [5:0] t0,
                               input logic [5:0] t1, input logic ep, input logic [5:0] ea,
                               input logic [3:0] erob, input int ecnt);
        vec_t v;
        v.dp = dp; v.da = da; v.drob = drob; v.drdy = drdy;
        v.wp = wp; v.t0 = t0; v.t1 = t1;
        v.ep = ep; v.ea = ea; v.erob = erob; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dp, input logic [5:0] a, input logic [3:0] rob,
                         input logic rdy, input logic [1:0] wp, input logic [5:0] t0,
                         input logic [5:0] t1, input logic flush, input logic stall);
        i_disp_p    = dp;
        i_disp_uop  = mk(a, rob);
        i_disp_rdy  = rdy;
        i_wb_p      = wp;
        i_wb_trgt   = {t1, t0};
        i_flush     = flush;
        i_agu_stall = stall;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 4'd0, 1'b0, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic p, input logic [5:0] a,
                              input logic [3:0] rob, input int cnt, input logic full);
        chk({name, " uop_p"}, 64'(o_uop_p), 64'(p));
        if (p) chk({name, " uop"}, 64'(o_uop), 64'(mk(a, rob)));
        chk({name, " count"}, 64'(o_count), 64'(cnt));
        chk({name, " full"}, 64'(o_disp_full), 64'(full));
    endtask

    initial begin
        // Vector table: each row is applied for one cycle, outputs checked after the edge.
`ifdef AGU_SCHED_BYPASS_EN
        vecs.push_back(V(1, 6'd2,  4'd3, 1, 2'b00, 0, 0,  1, 6'd2,  4'd3, 0));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));
`else
        vecs.push_back(V(1, 6'd2,  4'd3, 1, 2'b00, 0, 0,  0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  1, 6'd2,  4'd3, 0));
`endif
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));
        vecs.push_back(V(1, 6'd10, 4'd5, 0, 2'b00, 0, 0,  0, 0, 0, 1));
        vecs.push_back(V(1, 6'd20, 4'd6, 1, 2'b00, 0, 0,  0, 0, 0, 2));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  1, 6'd20, 4'd6, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b01, 6'd10, 0, 0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  1, 6'd10, 4'd5, 0));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));
`ifdef AGU_SCHED_BYPASS_EN
        vecs.push_back(V(1, 6'd33, 4'd7, 0, 2'b10, 0, 6'd33, 1, 6'd33, 4'd7, 0));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));
`else
        vecs.push_back(V(1, 6'd33, 4'd7, 0, 2'b10, 0, 6'd33, 0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  1, 6'd33, 4'd7, 0));
`endif
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));
        vecs.push_back(V(1, 6'd40, 4'd8, 0, 2'b00, 6'd40, 0, 0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b01, 6'd41, 0, 0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b10, 0, 6'd40, 0, 0, 0, 1));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  1, 6'd40, 4'd8, 0));
        vecs.push_back(V(0, 6'd0,  4'd0, 0, 2'b00, 0, 0,  0, 0, 0, 0));

        // Reset held low with dispatch active.
        i_rst = 1'b0;
        drive(1'b1, 6'd1, 4'd1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            expect_out($sformatf("reset%0d", c), 1'b0, 0, 0, 0, 1'b0);
            chk($sformatf("reset%0d uop", c), 64'(o_uop), 64'd0);
        end
        i_rst = 1'b1;
        idle();

        foreach (vecs[v]) begin
            drive(vecs[v].dp, vecs[v].da, vecs[v].drob, vecs[v].drdy,
                  vecs[v].wp, vecs[v].t0, vecs[v].t1, 1'b0, 1'b0);
            tick();
            expect_out($sformatf("vec%0d", v), vecs[v].ep, vecs[v].ea, vecs[v].erob,
                       vecs[v].ecnt, 1'b0);
        end
        idle();

        // Fill with four uops waiting on tag 50, then wake them all at once.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6'd50, 4'(k), 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
            tick();
            expect_out($sformatf("fill%0d", k), 1'b0, 0, 0, k + 1, k == 3);
        end
        drive(1'b1, 6'd54, 4'd9, 1'b1, 2'b01, 6'd50, 0, 1'b0, 1'b0);
        tick();
        expect_out("fill_wake", 1'b0, 0, 0, 4, 1'b1);
        drive(1'b1, 6'd54, 4'd9, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
        expect_out("fill_iss0", 1'b1, 6'd50, 4'd0, 3, 1'b0);
        idle();
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_out($sformatf("fill_iss%0d", k), 1'b1, 6'd50, 4'(k), 3 - k, 1'b0);
        end
        tick();
        expect_out("fill_drain", 1'b0, 0, 0, 0, 1'b0);

        // Stall holds the output; release takes the next ready uop.
        drive(1'b1, 6'd60, 4'd1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
`ifdef AGU_SCHED_BYPASS_EN
        expect_out("stall_d0", 1'b1, 6'd60, 4'd1, 0, 1'b0);
`else
        expect_out("stall_d0", 1'b0, 0, 0, 1, 1'b0);
`endif
        drive(1'b1, 6'd61, 4'd2, 1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("stall_d1", 1'b1, 6'd60, 4'd1, 1, 1'b0);
        drive(1'b0, 6'd0, 4'd0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out($sformatf("stall_hold%0d", c), 1'b1, 6'd60, 4'd1, 1, 1'b0);
        end
        idle();
        tick();
        expect_out("stall_rel", 1'b1, 6'd61, 4'd2, 0, 1'b0);
        tick();
        expect_out("stall_end", 1'b0, 0, 0, 0, 1'b0);

        // Flush with three held entries and a stalled issue.
        drive(1'b1, 6'd1, 4'd1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
`ifdef AGU_SCHED_BYPASS_EN
        expect_out("flush_f0", 1'b1, 6'd1, 4'd1, 0, 1'b0);
`else
        expect_out("flush_f0", 1'b0, 0, 0, 1, 1'b0);
`endif
        for (int k = 2; k <= 4; k++) begin
            drive(1'b1, 6'(k), 4'(k), 1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
            tick();
            expect_out($sformatf("flush_f%0d", k - 1), 1'b1, 6'd1, 4'd1, k - 1, 1'b0);
        end
        drive(1'b1, 6'd5, 4'd12, 1'b1, 2'b01, 6'd2, 0, 1'b1, 1'b1);
        tick();
        expect_out("flush_edge", 1'b0, 0, 0, 0, 1'b0);
        idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            expect_out($sformatf("flush_after%0d", c), 1'b0, 0, 0, 0, 1'b0);
        end

        // Reset arriving while a uop is issuing and another is held.
        drive(1'b1, 6'd7, 4'd5, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'd8, 4'd6, 1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        tick();
        expect_out("midrst_pre", 1'b1, 6'd7, 4'd5, 1, 1'b0);
        i_rst = 1'b0;
        drive(1'b1, 6'd9, 4'd7, 1'b1, 2'b01, 6'd8, 0, 1'b0, 1'b0);
        tick();
        expect_out("midrst", 1'b0, 0, 0, 0, 1'b0);
        chk("midrst uop", 64'(o_uop), 64'd0);
        i_rst = 1'b1;
        drive(1'b0, 6'd0, 4'd0, 1'b0, 2'b01, 6'd8, 0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        expect_out("midrst_post", 1'b0, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
